uart_rx_led: RTL

UART_RX_LED -- requirements
Module: uart_rx_led

---
 rtl/uart_rx_led.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_led.sv
// rtl/uart_rx_led.sv - 8N1 UART receiver that shows the last received ASCII hex digit on four LEDs
//
// Purpose: samples an asynchronous serial line at mid-bit, assembles 8N1
// frames LSB first, reports good bytes and framing errors with one-cycle
// pulses, and decodes ASCII hex characters onto a 4-bit LED value.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   reset      in   1  synchronous active-low reset
//   rx         in   1  asynchronous serial line, idle high
//   rx_data    out  8  last correctly framed byte
//   rx_valid   out  1  one-cycle pulse when rx_data is updated
//   frame_err  out  1  one-cycle pulse when the stop bit samples low
//   led        out  4  value of the last received ASCII hex character
//   led_state  out  4  copy of led
module uart_rx_led #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic [3:0] led,
  output logic [3:0] led_state
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t           r_state;
  logic             r_rx_meta;
  logic             r_rx_s;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_rx_data;
  logic             r_rx_valid;
  logic             r_frame_err;
  logic [3:0]       r_led;

  logic             w_hex_ok;
  logic [3:0]       w_hex_val;

  // The shift register is complete once in STOP, so decode it directly.
  // Letters have low nibble 1..6, which maps to 10..15 by adding 9.
  always_comb begin
    w_hex_ok  = 1'b0;
    w_hex_val = 4'h0;
    if (r_shift >= 8'h30 && r_shift <= 8'h39) begin
      w_hex_ok  = 1'b1;
      w_hex_val = r_shift[3:0];
    end else if ((r_shift >= 8'h41 && r_shift <= 8'h46) ||
                 (r_shift >= 8'h61 && r_shift <= 8'h66)) begin
      w_hex_ok  = 1'b1;
      w_hex_val = r_shift[3:0] + 4'd9;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_rx_meta   <= 1'b1;
      r_rx_s      <= 1'b1;
      r_cnt       <= '0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_led       <= 4'h0;
    end else begin
      r_rx_meta   <= rx;
      r_rx_s      <= r_rx_meta;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;

      case (r_state)
        IDLE: begin
          r_cnt     <= '0;
          r_bit_idx <= 3'd0;
          if (!r_rx_s) begin
            r_state <= START;
          end
        end

        // Re-check the line at mid start bit; a high line here was a glitch.
        START: begin
          if (r_cnt == CNT_HALF) begin
            r_cnt   <= '0;
            r_state <= r_rx_s ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        DATA: begin
          if (r_cnt == CNT_FULL) begin
            r_cnt              <= '0;
            r_shift[r_bit_idx] <= r_rx_s;
            r_bit_idx          <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_state <= STOP;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // Leaving STOP right at the sample point lets a back-to-back start
        // bit be caught even though the stop bit has not finished.
        STOP: begin
          if (r_cnt == CNT_FULL) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
              if (w_hex_ok) begin
                r_led <= w_hex_val;
              end
              r_state <= IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // A break (line held low) must not look like a stream of 0x00 frames.
        WAIT_HIGH: begin
          r_cnt <= '0;
          if (r_rx_s) begin
            r_state <= IDLE;
          end
        end

        default: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign led       = r_led;
  assign led_state = r_led;

endmodule
